// File: rtl/fdiv_pkg.sv
// rtl/fdiv_pkg.sv - shared op encodings, issue FSM states and FP constants for the fdiv issue block
package fdiv_pkg;

    localparam logic [1:0] FDIV_OP_DIV  = 2'd0;
    localparam logic [1:0] FDIV_OP_SQRT = 2'd1;
    localparam logic [1:0] FDIV_OP_RCP  = 2'd2;
    localparam logic [1:0] FDIV_OP_RSQ  = 2'd3;

    localparam logic [31:0] FP_QNAN = 32'h7fc00000;
    localparam logic [31:0] FP_ONE  = 32'h3f800000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/fdiv_watchdog.sv
// rtl/fdiv_watchdog.sv - WAIT-state watchdog; o_expire is high on the TIMEOUT-th enabled cycle
module fdiv_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && !o_expire) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // The first enabled cycle sees count 0, so the TIMEOUT-th one sees TIMEOUT-1.
    assign o_expire = i_enable && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fdiv_issue.sv
// rtl/fdiv_issue.sv - fdiv dispatch/done initiator; optional done watchdog under FDIV_ISSUE_TIMEOUT_EN
module fdiv_issue
    import fdiv_pkg::*;
#(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [1:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             dispatch,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [1:0]       op,
    input  logic             done,
    input  logic [31:0]      q,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_q,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_err
);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [1:0]        r_op;
    logic [TAG_W-1:0]  r_tag;
    logic [31:0]       r_res_q;
    logic [TAG_W-1:0]  r_res_tag;
    logic              r_res_err;
    logic              w_expire;

`ifdef FDIV_ISSUE_TIMEOUT_EN
    fdiv_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state == ISSUE),
        .i_enable (r_state == WAIT),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_expire         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        dispatch  = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) w_next = ISSUE;
            end
            ISSUE: begin
                dispatch = 1'b1;
                w_next   = WAIT;
            end
            WAIT: begin
                if (done || w_expire) w_next = HOLD;
            end
            HOLD: begin
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= '0;
            r_tag     <= '0;
            r_res_q   <= '0;
            r_res_tag <= '0;
            r_res_err <= 1'b0;
        end else begin
            if (r_state == IDLE && req_valid) begin
                r_a   <= req_a;
                r_b   <= req_b;
                r_op  <= req_op;
                r_tag <= req_tag;
            end
            // done takes priority over a watchdog expiry in the same cycle
            if (r_state == WAIT && done) begin
                r_res_q   <= q;
                r_res_tag <= r_tag;
                r_res_err <= 1'b0;
            end else if (r_state == WAIT && w_expire) begin
                r_res_q   <= FP_QNAN;
                r_res_tag <= r_tag;
                r_res_err <= 1'b1;
            end
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign op        = r_op;
    assign res_valid = (r_state == HOLD);
    assign res_q     = r_res_q;
    assign res_tag   = r_res_tag;
`ifdef FDIV_ISSUE_TIMEOUT_EN
    assign res_err   = r_res_err;
`else
    assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_issue.sv
// tb/tb_fdiv_issue.sv - self-checking bench for fdiv_issue with a latency-programmable fdiv model
module tb_fdiv_issue;

    localparam int TAG_W = 4;
`ifdef FDIV_ISSUE_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [1:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             dispatch;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [1:0]       op;
    logic             done;
    logic [31:0]      q;
    logic             res_valid;
    logic             res_ready;
    logic [31:0]      res_q;
    logic [TAG_W-1:0] res_tag;
    logic             res_err;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    fdiv_issue #(.TAG_W(TAG_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .dispatch(dispatch), .a(a), .b(b), .op(op),
        .done(done), .q(q),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_q(res_q), .res_tag(res_tag), .res_err(res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference quotients for the named vectors; any other pair gets an opaque mix.
    function automatic logic [31:0] fdiv_fn(input logic [31:0] x, input logic [31:0] y);
        case ({x, y})
            {32'h3f800000, 32'h3f000000}: return 32'h40000000;
            {32'h40490fdb, 32'h402df854}: return 32'h3f93eee0;
            {32'h402df854, 32'h40490fdb}: return 32'h3f5d816a;
            {32'h00000000, 32'h3f800000}: return 32'h00000000;
            {32'h3f800000, 32'h3f800000}: return 32'h3f800000;
            {32'h3f800000, 32'h00000000}: return 32'h7f800000;
            default: return x ^ {y[15:0], y[31:16]};
        endcase
    endfunction

    int          lat = 5;
    bit          never_done = 1'b0;
    int          cnt = 0;
    int          disp_total = 0;
    int          disp_b2b = 0;
    int          last_disp_cyc = -1;
    bit          prev_disp = 1'b0;
    logic [31:0] cap_a, cap_b;
    logic [1:0]  cap_op;
    logic [31:0] rs_q[$];
    logic [TAG_W-1:0] rs_tag[$];
    int          rs_cyc[$];

    // fdiv model: done clears on dispatch and rises lat cycles later; reset does not abort it.
    always @(negedge clk) begin
        if (dispatch) begin
            done = 1'b0;
            cnt = lat;
            cap_a = a;
            cap_b = b;
            cap_op = op;
            disp_total++;
            last_disp_cyc = cyc;
            if (prev_disp) disp_b2b++;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && !never_done) begin
                done = 1'b1;
                q = fdiv_fn(cap_a, cap_b);
            end
        end
        prev_disp = dispatch;
        if (res_valid && res_ready) begin
            rs_q.push_back(res_q);
            rs_tag.push_back(res_tag);
            rs_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [31:0] ra, input logic [31:0] rb, input logic [1:0] rop,
                        input logic [TAG_W-1:0] rt, output int acc);
        req_valid = 1'b1; req_a = ra; req_b = rb; req_op = rop; req_tag = rt;
        acc = -1;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin acc = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_res(output int rc);
        rc = -1;
        for (int i = 0; i < 300; i++) begin
            if (res_valid) begin rc = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || dispatch !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got rdy=%b disp=%b rv=%b want 1 0 0", req_ready, dispatch, res_valid);
        end
        vectors++;
        if ({a, b, op} !== 66'd0) begin
            errors++;
            $display("FAIL reset_ops got a=%h b=%h op=%h want 0", a, b, op);
        end
        vectors++;
        if ({res_q, res_tag, res_err} !== 37'd0) begin
            errors++;
            $display("FAIL reset_res got q=%h tag=%h err=%b want 0", res_q, res_tag, res_err);
        end
    endtask

    task automatic test_basic;
        int acc, rc, d0;
        lat = 5; res_ready = 1'b1; d0 = disp_total;
        send(32'h3f800000, 32'h3f000000, 2'd0, 4'd3, acc);
        wait_res(rc);
        vectors++;
        if (last_disp_cyc !== acc + 1) begin
            errors++;
            $display("FAIL basic_disp_cycle got %0d want %0d", last_disp_cyc, acc + 1);
        end
        vectors++;
        if (rc !== acc + lat + 2) begin
            errors++;
            $display("FAIL basic_latency got %0d want %0d", rc, acc + lat + 2);
        end
        vectors++;
        if (res_q !== 32'h40000000 || res_tag !== 4'd3 || res_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_result got q=%h tag=%h err=%b want 40000000 3 0", res_q, res_tag, res_err);
        end
        @(negedge clk);
        vectors++;
        if (disp_total - d0 !== 1) begin
            errors++;
            $display("FAIL basic_disp_count got %0d want 1", disp_total - d0);
        end
    endtask

    task automatic test_hold;
        int acc, rc, bad;
        lat = 3; res_ready = 1'b0; bad = 0;
        send(32'h40490fdb, 32'h402df854, 2'd1, 4'd9, acc);
        wait_res(rc);
        req_valid = 1'b1; req_a = 32'h1; req_b = 32'h2; req_tag = 4'd1;
        for (int i = 0; i < 10; i++) begin
            vectors++;
            if (res_valid !== 1'b1 || res_q !== 32'h3f93eee0 || res_tag !== 4'd9 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d] got rv=%b q=%h tag=%h rdy=%b want 1 3f93eee0 9 0",
                         i, res_valid, res_q, res_tag, req_ready);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        vectors++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_ready_same got %b want 0", req_ready);
        end
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release got rdy=%b rv=%b want 1 0", req_ready, res_valid);
        end
    endtask

    task automatic test_back_to_back;
        int acc1, acc2;
        lat = 2; res_ready = 1'b1;
        rs_q.delete(); rs_tag.delete(); rs_cyc.delete();
        req_valid = 1'b1; req_a = 32'h402df854; req_b = 32'h40490fdb; req_op = 2'd0; req_tag = 4'd1;
        acc1 = -1; acc2 = -1;
        for (int i = 0; i < 100 && acc1 < 0; i++) begin
            if (req_ready) acc1 = cyc;
            @(negedge clk);
        end
        req_a = 32'h00000000; req_b = 32'h3f800000; req_tag = 4'd2;
        for (int i = 0; i < 100 && acc2 < 0; i++) begin
            if (req_ready) acc2 = cyc;
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 100 && rs_q.size() < 2; i++) @(negedge clk);
        vectors++;
        if (rs_q.size() !== 2) begin
            errors++;
            $display("FAIL b2b_count got %0d want 2", rs_q.size());
        end else begin
            vectors++;
            if (rs_q[0] !== 32'h3f5d816a || rs_tag[0] !== 4'd1 || rs_q[1] !== 32'h0 || rs_tag[1] !== 4'd2) begin
                errors++;
                $display("FAIL b2b_results got %h/%h %h/%h want 3f5d816a/1 00000000/2",
                         rs_q[0], rs_tag[0], rs_q[1], rs_tag[1]);
            end
            vectors++;
            if (acc2 !== rs_cyc[0] + 1) begin
                errors++;
                $display("FAIL b2b_accept_gap got %0d want %0d", acc2, rs_cyc[0] + 1);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc, rc, seen;
        lat = 4; res_ready = 1'b1; seen = 0;
        send(32'h40490fdb, 32'h3f800000, 2'd2, 4'd7, acc);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || res_valid !== 1'b0 || {a, b, op, res_q, res_tag, res_err} !== 103'd0) begin
            errors++;
            $display("FAIL rstmid_values got rdy=%b rv=%b a=%h b=%h op=%h q=%h want reset values",
                     req_ready, res_valid, a, b, op, res_q);
        end
        for (int i = 0; i < 6; i++) begin
            if (res_valid) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rstmid_stale_done got %0d res_valid cycles want 0", seen);
        end
        send(32'h3f800000, 32'h3f800000, 2'd0, 4'd5, acc);
        wait_res(rc);
        vectors++;
        if (rc < 0 || res_q !== 32'h3f800000 || res_tag !== 4'd5) begin
            errors++;
            $display("FAIL rstmid_next got rc=%0d q=%h tag=%h want 3f800000 5", rc, res_q, res_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_random;
        int acc, rc;
        logic [31:0] ra, rb;
        logic [1:0] rop;
        logic [TAG_W-1:0] rt;
        for (int n = 0; n < 20; n++) begin
            ra = $urandom; rb = $urandom; rop = 2'($urandom_range(0, 3)); rt = TAG_W'($urandom_range(0, 15));
            lat = $urandom_range(1, 6);
            res_ready = 1'b0;
            send(ra, rb, rop, rt, acc);
            wait_res(rc);
            vectors++;
            if (cap_a !== ra || cap_b !== rb || cap_op !== rop) begin
                errors++;
                $display("FAIL rand_operands[%0d] got %h %h %h want %h %h %h", n, cap_a, cap_b, cap_op, ra, rb, rop);
            end
            vectors++;
            if (rc !== acc + lat + 2 || res_q !== fdiv_fn(ra, rb) || res_tag !== rt || res_err !== 1'b0) begin
                errors++;
                $display("FAIL rand_result[%0d] got rc=%0d q=%h tag=%h err=%b want rc=%0d q=%h tag=%h err=0",
                         n, rc, res_q, res_tag, res_err, acc + lat + 2, fdiv_fn(ra, rb), rt);
            end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
        res_ready = 1'b1;
    endtask

`ifdef FDIV_ISSUE_TIMEOUT_EN
    task automatic test_timeout;
        int acc, rc;
        never_done = 1'b1; res_ready = 1'b1;
        send(32'h40490fdb, 32'h402df854, 2'd0, 4'd6, acc);
        wait_res(rc);
        vectors++;
        if (rc !== acc + TMO + 2 || res_q !== 32'h7fc00000 || res_err !== 1'b1 || res_tag !== 4'd6) begin
            errors++;
            $display("FAIL timeout_abort got rc=%0d q=%h err=%b tag=%h want rc=%0d 7fc00000 1 6",
                     rc, res_q, res_err, res_tag, acc + TMO + 2);
        end
        @(negedge clk);
        never_done = 1'b0;
        lat = TMO;
        send(32'h3f800000, 32'h00000000, 2'd0, 4'd11, acc);
        wait_res(rc);
        vectors++;
        if (rc !== acc + TMO + 2 || res_q !== 32'h7f800000 || res_err !== 1'b0 || res_tag !== 4'd11) begin
            errors++;
            $display("FAIL timeout_done_wins got rc=%0d q=%h err=%b tag=%h want rc=%0d 7f800000 0 11",
                     rc, res_q, res_err, res_tag, acc + TMO + 2);
        end
        @(negedge clk);
    endtask
`else
    task automatic test_no_timeout;
        int acc, seen;
        never_done = 1'b1; res_ready = 1'b1; seen = 0;
        send(32'h3f800000, 32'h3f000000, 2'd0, 4'd4, acc);
        for (int i = 0; i < 100; i++) begin
            if (res_valid || res_err) seen++;
            @(negedge clk);
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL no_timeout_wait got %0d result cycles want 0", seen);
        end
        never_done = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask
`endif

    task automatic test_dispatch_spacing;
        vectors++;
        if (disp_b2b !== 0) begin
            errors++;
            $display("FAIL dispatch_spacing got %0d consecutive pulses want 0", disp_b2b);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        res_ready = 1'b0; done = 1'b0; q = '0;
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef FDIV_ISSUE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_dispatch_spacing();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/fdiv_issue.md
Name: fdiv_issue

Overview:
- Initiator side of the fdiv dispatch/done protocol.
- Accepts divide requests from the core pipeline over a valid/ready handshake and latches the operands.
- Drives a one-cycle dispatch pulse plus a/b/op into fdiv, waits for done, captures q, and returns a tagged result over a second valid/ready handshake.
- Sits between the execute stage and the multi-cycle fdiv unit, so the pipeline never has to track fdiv timing.

Parameters:
- TAG_W, 4, width of the request/result tag.
- TIMEOUT, 64, cycles to wait for done before aborting (used only when FDIV_ISSUE_TIMEOUT_EN is defined).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_a  in  32  IEEE-754 single dividend.
- req_b  in  32  IEEE-754 single divisor.
- req_op  in  2  operation code, forwarded unchanged to fdiv.
- req_tag  in  TAG_W  opaque tag.
- dispatch  out  1  start pulse to fdiv.
- a  out  32  operand to fdiv.
- b  out  32  operand to fdiv.
- op  out  2  operation code to fdiv.
- done  in  1  fdiv completion level.
- q  in  32  fdiv result.
- res_valid  out  1  result present.
- res_ready  in  1  consumer accepts the result.
- res_q  out  32  captured quotient.
- res_tag  out  TAG_W  tag of the request that produced res_q.
- res_err  out  1  result was aborted by timeout; always 0 without FDIV_ISSUE_TIMEOUT_EN.

Behaviour:
- Reset values: state=IDLE; req_ready=1; dispatch=0; a=b=0; op=0; res_valid=0; res_q=0; res_tag=0; res_err=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_a/b/op/tag into a/b/op and the tag register, then go to ISSUE.
  - done is ignored in IDLE.
- ISSUE (exactly 1 cycle):
  - dispatch=1, req_ready=0, then go to WAIT.
  - a/b/op stay stable from ISSUE until leaving WAIT.
- WAIT:
  - done is sampled from the first WAIT cycle onward. fdiv clears done on the dispatch edge, so a stale done is never seen.
  - On done=1: res_q<=q, res_tag<=tag, res_err<=0, res_valid<=1, go to HOLD.
- HOLD:
  - Outputs stay stable while res_valid=1 and res_ready=0.
  - On res_ready: res_valid<=0, go to IDLE.
  - req_ready stays 0 in HOLD; there is no overlap.
- Minimum occupancy: with a 1-cycle fdiv and res_ready tied high, a request is accepted in cycle 0, dispatch is in cycle 1, res_valid rises in cycle 3, and the next request is accepted in cycle 4.
- Operands pass through bit-exact. No arithmetic or NaN inspection is done in this block; special values (0/0, x/0, NaN) are fdiv's responsibility.
- Reset mid-operation (any state):
  - Return to IDLE with reset values next cycle.
  - A later done from the abandoned fdiv op is ignored, because IDLE ignores done.
- Simultaneous res_ready and new req_valid in HOLD: the request waits one cycle and is accepted in IDLE.
- dispatch never asserts in two consecutive cycles.

Optional Feature:
FDIV_ISSUE_TIMEOUT_EN
- Defined:
  - A watchdog counter clears on entering WAIT and increments each WAIT cycle.
  - If done has not arrived when the count reaches TIMEOUT: res_q<=32'h7fc00000 (qNaN), res_err<=1, res_tag<=tag, res_valid<=1, go to HOLD.
  - If done and expiry occur in the same cycle, done wins.
- Undefined: no counter; WAIT lasts until done; res_err is tied to 0.

Decomposition:
- Package fdiv_pkg:
  - FDIV_OP_* op encodings (2-bit).
  - State enum: IDLE, ISSUE, WAIT, HOLD.
  - FP_QNAN = 32'h7fc00000.
  - FP_ONE = 32'h3f800000.
- Sub-module fdiv_watchdog: counter with clear/enable/expire, instantiated only under FDIV_ISSUE_TIMEOUT_EN.

Test Plan:
1. Request a=3f800000, b=3f000000, tag=3. Bench fdiv model with 5-cycle latency returns 40000000. Required: exactly one dispatch pulse one cycle after acceptance; res_q=40000000, res_tag=3, res_err=0.
2. Request a=40490fdb, b=402df854 with res_ready held low for 10 cycles. Required: res_q=3f93eee0 held stable and res_valid held high throughout; req_ready=0 until the cycle after res_ready.
3. Back-to-back requests: e/pi then 0/1.0 with res_ready=1. Required: results 3f5d816a then 00000000, in order, tags preserved; the second acceptance is exactly 1 cycle after the first result handshake.
4. Assert rst while in WAIT, then let the model raise done 3 cycles later. Required: no res_valid; outputs at reset values; next request a=3f800000, b=3f800000 returns 3f800000.
5. With FDIV_ISSUE_TIMEOUT_EN and TIMEOUT=8, the model never raises done. Required: res_valid after 8 WAIT cycles with res_q=7fc00000, res_err=1.
6. With FDIV_ISSUE_TIMEOUT_EN, done arrives on the expiry cycle with q=7f800000 (1.0/0). Required: res_q=7f800000, res_err=0.
